// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, entry type and width helpers for the fetch queue
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 16;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] pcplus4;
    } fetch_entry_t;
    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry IF/ID buffer with valid/ready on both sides, flush and NOP-when-empty.
// Ports: clk, rst (async active-low), flush; enq_valid/enq_ready with pc_in, instr_in, pcplus4_in;
// deq_valid/deq_ready with pc_out, instr_out, pcplus4_out; count = occupancy.
// Optional macro FETCH_QUEUE_BYPASS_EN: an empty queue forwards the incoming entry combinationally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [XLEN-1:0]            pc_in,
    input  logic [31:0]                instr_in,
    input  logic [XLEN-1:0]            pcplus4_in,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [XLEN-1:0]            pc_out,
    output logic [31:0]                instr_out,
    output logic [XLEN-1:0]            pcplus4_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    fetch_entry_t mem [DEPTH];
    fetch_entry_t in_entry, head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic bypass, through, wr, rd;
    assign in_entry = '{pc: pc_in, instr: instr_in, pcplus4: pcplus4_in};
`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = (cnt == '0) && enq_valid && !flush;
`else
    assign bypass = 1'b0;
`endif
    // enq_ready deliberately ignores deq_ready so PCWrite has no path from decode
    assign enq_ready = (cnt != CW'(DEPTH)) && !flush;
    assign deq_valid = (cnt != '0) || bypass;
    // a bypassed entry consumed in the same cycle never touches storage
    assign through = bypass && deq_ready;
    assign wr = enq_valid && enq_ready && !through;
    assign rd = (cnt != '0) && deq_ready && !flush;
    assign count = cnt;
    always_comb
        head = bypass ? in_entry : (cnt != '0) ? mem[rd_ptr] : '{pc: '0, instr: NOP_INSTR, pcplus4: '0};
    assign pc_out = head.pc;
    assign instr_out = head.instr;
    assign pcplus4_out = head.pcplus4;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
        end else begin
            if (wr) wr_ptr <= nxt(wr_ptr);
            if (rd) rd_ptr <= nxt(rd_ptr);
            cnt <= (wr && !rd) ? cnt + CW'(1) : (rd && !wr) ? cnt - CW'(1) : cnt;
        end
    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= in_entry;
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised-depth instruction fetch buffer. It replaces the single-entry IF/ID register between instruction fetch and decode in the pipelined core.
- It decouples fetch from decode stalls with a valid/ready handshake on both sides.
- It supports a single-cycle flush for control hazards resolved in EX.
- When empty, it presents a canonical NOP to decode so that bubbles are architecturally harmless.

Parameters:
- XLEN, 32: width of PC, instruction and PC+4 fields.
- DEPTH, 4: number of entries. Legal range is 2..16 and need not be a power of two.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  discard all entries (branch taken or jump in EX).
- enq_valid  in  1  fetch presents an entry.
- enq_ready  out  1  queue accepts an entry this cycle.
- pc_in  in  XLEN  fetch PC.
- instr_in  in  32  fetched instruction.
- pcplus4_in  in  XLEN  fetch PC+4.
- deq_valid  out  1  head entry valid for decode.
- deq_ready  in  1  decode consumes the head (low = decode stalled).
- pc_out  out  XLEN  head PC.
- instr_out  out  32  head instruction, or NOP when empty.
- pcplus4_out  out  XLEN  head PC+4.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0. As a result deq_valid=0, enq_ready=1, instr_out=32'h00000013, pc_out=0, pcplus4_out=0. Storage contents are don't-care.
- Enqueue handshake: fires when enq_valid && enq_ready at the clock edge. The entry is written at wr_ptr, then wr_ptr advances.
- Dequeue handshake: fires when deq_valid && deq_ready. rd_ptr advances.
- enq_ready = (count != DEPTH) && !flush. It is not relieved by a same-cycle dequeue, so there is no combinational path from deq_ready to enq_ready.
- deq_valid = (count != 0). The outputs are driven combinationally from storage[rd_ptr].
- Empty outputs: instr_out=NOP (addi x0,x0,0), pc_out=0, pcplus4_out=0.
- Latency: an entry enqueued at edge N is visible on the outputs after edge N, i.e. one cycle.
- Pointer wrap: a pointer equal to DEPTH-1 wraps to 0 by explicit compare, not a power-of-two mask.
- count update: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- Simultaneous enqueue and dequeue when not full and not empty: both fire and count is unchanged.
- Full: enq_valid is held off by enq_ready=0. The upstream PC must hold, so enq_ready maps onto PCWrite.
- Empty with deq_ready=1: no dequeue, no pointer change.
- Flush priority: flush=1 at an edge sets wr_ptr=rd_ptr=count=0. The same-cycle enqueue and dequeue are both discarded. The next cycle presents the NOP.
- Reset mid-flush or mid-operation: reset dominates asynchronously, and all in-flight entries are lost.
- Storage holds no reset-dependent data; only the pointers and count are reset.

Optional Feature:
- FETCH_QUEUE_BYPASS_EN defined: when count==0 && enq_valid && !flush, the outputs are driven straight from the inputs with deq_valid=1.
  - If deq_ready is also 1, the entry is consumed in the same cycle and never written. Count and pointers are unchanged.
  - If deq_ready is 0, the entry is written normally.
  - Minimum latency becomes 0 cycles.
- Undefined: no bypass path; minimum latency is 1 cycle as above.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR = 32'h00000013.
  - Typedef fetch_entry_t, a packed struct {pc, instr, pcplus4}, parameterised via the XLEN localparam.
  - Pointer/count width helper localparams.
- No sub-module. Pointer, count and storage logic stays in fetch_queue, since the storage is a small array of fetch_entry_t.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles and release. Required: count=0, deq_valid=0, enq_ready=1, instr_out=0x00000013.
- Fill to full (DEPTH=4, deq_ready=0):
  - Enqueue PCs 0x00, 0x04, 0x08, 0x0C.
  - Required: count=4 and enq_ready=0; a 5th enq_valid is not accepted.
  - Head remains pc_out=0x00.
- Streaming (enq_valid=1, deq_ready=1 every cycle, PCs 0x100 upward by 4): after the first entry, count stays 1. Decode sees 0x100, 0x104, ... in order with no gaps, including across the pointer wrap at entry 3 to 0.
- Flush with simultaneous handshakes: count=3, flush=1, enq_valid=1 and deq_ready=1 in the same cycle. Required next cycle: count=0, deq_valid=0, instr_out=NOP. The flushed-cycle enqueue never appears.
- Non-power-of-two depth (DEPTH=3): run 10 mixed enqueue/dequeue cycles.
  - Required: FIFO order preserved and count never exceeds 3.
  - Pointers wrap 2 to 0.
- Asynchronous reset mid-operation: assert rst=0 between clock edges with count=2. Required: count=0 and deq_valid=0 immediately, without waiting for an edge.
- With FETCH_QUEUE_BYPASS_EN:
  - Empty queue, enq_valid=1, deq_ready=1, instr_in=0x00500093. Required: same-cycle deq_valid=1, instr_out=0x00500093, count stays 0.
  - Repeat with deq_ready=0. Required: the entry is written and count=1.
